alu_arbiter: RTL

- Shares the single 8-bit ALU between two requesters (req 0, req 1), e.g. the execute stage and a debug/DMA port.
- Round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Registers the granted operands, drives the ALU for one cycle, captures y/zero, then returns the result to the granted requester.
- Sits between the requesters and the alu instance; the ALU itself stays combinational and unchanged.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 21 ++
 rtl/alu_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and state encoding for the alu arbiter
package alu_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_OPW   = 3;

    localparam logic [DEF_OPW-1:0] OP_ADD = 3'b000;
    localparam logic [DEF_OPW-1:0] OP_SUB = 3'b001;
    localparam logic [DEF_OPW-1:0] OP_AND = 3'b010;
    localparam logic [DEF_OPW-1:0] OP_OR  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // One-hot response bit for a single-bit requester index.
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2 (
    input  logic       en,
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                // On contention the requester that did not win last time goes first.
                gnt = last ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational alu between two requesters
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OPW-1:0]   req_op0,
    input  logic [OPW-1:0]   req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_y,
    output logic             resp_zero,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic             busy
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] gnt;
    logic       arb_en;
    logic       owner;
    logic       last_grant;
    logic       resp_done;

    assign arb_en    = (state == S_IDLE);
    assign resp_done = (state == S_RESP) && resp_ready[owner];

    rr_arb2 u_arb (
        .en   (arb_en),
        .req  (req_valid),
        .last (last_grant),
        .gnt  (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (gnt != 2'b00) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_RESP;
            S_RESP:  if (resp_ready[owner]) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = gnt;
        resp_valid = 2'b00;
        if (state == S_RESP) begin
            resp_valid = owner_onehot(owner);
        end
        busy = (state != S_IDLE);
    end

    // Operands only move on a grant, so the alu inputs are stable for the whole operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            resp_y     <= '0;
            resp_zero  <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (gnt != 2'b00) begin
                owner  <= gnt[1];
                alu_op <= gnt[1] ? req_op1 : req_op0;
                alu_a  <= gnt[1] ? req_a1  : req_a0;
                alu_b  <= gnt[1] ? req_b1  : req_b0;
            end
            if (state == S_EXEC) begin
                resp_y    <= alu_y;
                resp_zero <= alu_zero;
            end
            if (resp_done) begin
                last_grant <= owner;
            end
        end
    end

endmodule
